// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns over a 128-bit state, processed COLS_PER_CYCLE columns per clock.
// Valid/ready on both sides; the result is held in the working register until it is taken.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [127:0] i_state,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [127:0] o_state
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $fatal(1, "COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter step and the counter bits that identify a column group (low bits are
    // don't-care when several columns are done per cycle; all bits ignored for 4).
    localparam logic [1:0] STEP    = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] HI_MASK = ~2'(COLS_PER_CYCLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t       state_reg, state_next;
    logic [1:0]   cnt_reg, cnt_next, cnt_adv;
    logic [127:0] work_reg, work_next, work_calc;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Each column is rewritten only when the counter points at its group.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            logic [31:0] col_cur;
            logic        col_sel;
            assign col_cur = work_reg[127-32*gi -: 32];
            assign col_sel = ((2'(gi) & HI_MASK) == (cnt_reg & HI_MASK));
            assign work_calc[127-32*gi -: 32] = col_sel ? inv_mix_col(col_cur) : col_cur;
        end
    endgenerate

    assign cnt_adv = cnt_reg + STEP;
    assign i_ready = rst && ((state_reg == IDLE) || (state_reg == DONE && o_ready));
    assign accept  = i_valid && i_ready;
    assign o_valid = (state_reg == DONE);
    assign o_state = work_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        work_next  = work_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                    work_next  = i_state;
                    cnt_next   = 2'd0;
                end
            end
            CALC: begin
                work_next = work_calc;
                cnt_next  = cnt_adv;
                if ((cnt_adv & HI_MASK) == 2'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (o_ready) begin
                    if (accept) begin
                        state_next = CALC;
                        work_next  = i_state;
                        cnt_next   = 2'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            work_reg  <= 128'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            work_reg  <= work_next;
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed-vector bench for inv_mix_columns_seq: table of known AES column results plus
// stall, back-to-back, mid-operation reset and multi-width latency sequences.
module tb_inv_mix_columns_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready = 1'b0;
    logic [127:0] i_state = 128'h0;

    logic         i_ready, o_valid;
    logic [127:0] o_state;
    logic         i_ready2, o_valid2;
    logic [127:0] o_state2;
    logic         i_ready4, o_valid4;
    logic [127:0] o_state4;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_state(i_state),
        .o_valid(o_valid), .o_ready(o_ready), .o_state(o_state));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready2), .i_state(i_state),
        .o_valid(o_valid2), .o_ready(o_ready), .o_state(o_state2));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready4), .i_state(i_state),
        .o_valid(o_valid4), .o_ready(o_ready), .o_state(o_state4));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vector(input int idx, input logic [127:0] din, input logic [127:0] dout);
        int lat;
        check($sformatf("vec%0d_idle_ready", idx), 128'(i_ready), 128'(1));
        i_state = din;
        i_valid = 1'b1;
        o_ready = 1'b0;
        tick;
        i_valid = 1'b0;
        i_state = ~din;
        lat = 0;
        while (lat < 20) begin
            tick;
            lat++;
            if (o_valid) break;
        end
        check($sformatf("vec%0d_latency", idx), 128'(lat), 128'(N));
        check($sformatf("vec%0d_result", idx), o_state, dout);
        o_ready = 1'b1;
        tick;
        o_ready = 1'b0;
        check($sformatf("vec%0d_retired", idx), 128'(o_valid), 128'(0));
        $display("vec %0d in=%h out=%h lat=%0d", idx, din, o_state, lat);
    endtask

    task automatic multi_width(input int idx, input logic [127:0] din, input logic [127:0] dout);
        int l1, l2, l4;
        i_state = din;
        i_valid = 1'b1;
        o_ready = 1'b0;
        tick;
        i_valid = 1'b0;
        l1 = 0; l2 = 0; l4 = 0;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (o_valid  && l1 == 0) l1 = c;
            if (o_valid2 && l2 == 0) l2 = c;
            if (o_valid4 && l4 == 0) l4 = c;
        end
        check($sformatf("mw%0d_lat_cpc1", idx), 128'(l1), 128'(4));
        check($sformatf("mw%0d_lat_cpc2", idx), 128'(l2), 128'(2));
        check($sformatf("mw%0d_lat_cpc4", idx), 128'(l4), 128'(1));
        check($sformatf("mw%0d_out_cpc1", idx), o_state,  dout);
        check($sformatf("mw%0d_out_cpc2", idx), o_state2, dout);
        check($sformatf("mw%0d_out_cpc4", idx), o_state4, dout);
        $display("multi %0d in=%h lat=%0d/%0d/%0d", idx, din, l1, l2, l4);
        o_ready = 1'b1;
        tick;
        o_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k, last, saw;

        vecs[0] = '{din: {4{32'h8e4da1bc}}, dout: {4{32'hdb135345}}};
        vecs[1] = '{din: {32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6, 32'hc6c6c6c6},
                    dout: {32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5, 32'hc6c6c6c6}};
        vecs[2] = '{din: {4{32'h01010101}}, dout: {4{32'h01010101}}};
        vecs[3] = '{din: 128'h0, dout: 128'h0};
        vecs[4] = '{din: {32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'h9fdc589d},
                    dout: {32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c, 32'hf20a225c}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_i_ready", 128'(i_ready), 128'(0));
        check("rst_o_valid", 128'(o_valid), 128'(0));
        check("rst_o_state", o_state, 128'h0);
        rst = 1'b1;
        #1;
        check("rst_release_ready", 128'(i_ready), 128'(1));

        // Latency and result for every column width
        multi_width(0, vecs[0].din, vecs[0].dout);
        multi_width(1, vecs[1].din, vecs[1].dout);

        // Table-driven vectors
        for (int i = 0; i < 5; i++) begin
            run_vector(i, vecs[i].din, vecs[i].dout);
        end

        // Stall in DONE: output stable, input ignored
        i_state = vecs[1].din;
        i_valid = 1'b1;
        tick;
        i_valid = 1'b0;
        repeat (N) tick;
        check("stall_valid_start", 128'(o_valid), 128'(1));
        for (int c = 0; c < 10; c++) begin
            i_state = {4{$urandom}};
            i_valid = 1'(c % 2);
            tick;
            check($sformatf("stall%0d_valid", c), 128'(o_valid), 128'(1));
            check($sformatf("stall%0d_state", c), o_state, vecs[1].dout);
            check($sformatf("stall%0d_ready", c), 128'(i_ready), 128'(0));
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        tick;
        o_ready = 1'b0;
        check("stall_release_valid", 128'(o_valid), 128'(0));
        check("stall_release_ready", 128'(i_ready), 128'(1));
        $display("stall sequence out=%h", vecs[1].dout);

        // Back-to-back with i_valid and o_ready held high
        k = 0;
        last = 0;
        i_state = vecs[0].din;
        i_valid = 1'b1;
        o_ready = 1'b1;
        for (int c = 0; c < 60 && k < 3; c++) begin
            tick;
            if (o_valid) begin
                check($sformatf("b2b%0d_state", k), o_state, vecs[k].dout);
                check($sformatf("b2b%0d_ready", k), 128'(i_ready), 128'(1));
                if (k > 0) check($sformatf("b2b%0d_spacing", k), 128'(c - last), 128'(N + 1));
                $display("b2b %0d out=%h cycle=%0d", k, o_state, c);
                last = c;
                k++;
                if (k < 3) i_state = vecs[k].din;
                else i_valid = 1'b0;
            end
        end
        check("b2b_count", 128'(k), 128'(3));
        tick;
        o_ready = 1'b0;
        check("b2b_idle", 128'(o_valid), 128'(0));

        // Reset in the middle of CALC
        i_state = vecs[1].din;
        i_valid = 1'b1;
        tick;
        i_valid = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        check("midrst_ready_low", 128'(i_ready), 128'(0));
        check("midrst_valid_low", 128'(o_valid), 128'(0));
        check("midrst_state_clr", o_state, 128'h0);
        rst = 1'b1;
        #1;
        check("midrst_ready_after", 128'(i_ready), 128'(1));
        saw = 0;
        repeat (8) begin
            tick;
            if (o_valid) saw++;
        end
        check("midrst_no_valid", 128'(saw), 128'(0));
        $display("mid-calc reset sequence done");
        run_vector(5, vecs[4].din, vecs[4].dout);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
